// File: rtl/mem_access_unit.sv
// Purpose: MEM stage; issues one 64-bit data-memory access per load/store and feeds MEM/WB.
// Latency: 1 cycle for ALU ops/errors; accesses finish 1 cycle after mem_ready or on timeout.
// Backpressure: stall (combinational) holds EX/MEM while an aligned access is outstanding.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic [63:0] AluOut_in,
  input  logic [63:0] DataOut_in,
  input  logic [4:0]  Rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        valid_out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [63:0] ReadData_Out,
  output logic [63:0] AluOut_Out,
  output logic [4:0]  Rd_out,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_mem_req, r_mem_we;
  logic [63:0] r_mem_addr, r_mem_wdata;
  logic        r_acc_rw, r_acc_m2r;
  logic [4:0]  r_acc_rd;
  logic        r_valid_out, r_regwrite_out, r_memtoreg_out;
  logic [63:0] r_rdata_out, r_alu_out;
  logic [4:0]  r_rd_out;
  logic        r_err_misalign, r_err_timeout;

  logic        w_mem_op, w_bad, w_accept, w_done, w_tmo;

  // Both MemRead and MemWrite set is not a memory op; it is rejected like a misaligned access.
  assign w_mem_op = valid_in & (MemRead_in ^ MemWrite_in);
  assign w_bad    = valid_in & ((MemRead_in & MemWrite_in) |
                                (w_mem_op & (AluOut_in[2:0] != 3'b000)));
  assign w_accept = w_mem_op & (AluOut_in[2:0] == 3'b000);

  // Next-state and stall; mem_ready beats the timeout when both land in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_accept;
        if (w_accept) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        stall = ~mem_ready & (r_cnt != LP_LAST);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Memory request, access latches, MEM/WB outputs and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_acc_rw       <= 1'b0;
      r_acc_m2r      <= 1'b0;
      r_acc_rd       <= '0;
      r_valid_out    <= 1'b0;
      r_regwrite_out <= 1'b0;
      r_memtoreg_out <= 1'b0;
      r_rdata_out    <= '0;
      r_alu_out      <= '0;
      r_rd_out       <= '0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!valid_in) begin
            r_valid_out    <= 1'b0;
            r_regwrite_out <= 1'b0;
          end else if (w_accept) begin
            r_mem_req      <= 1'b1;
            r_mem_we       <= MemWrite_in;
            r_mem_addr     <= AluOut_in;
            r_mem_wdata    <= DataOut_in;
            r_acc_rw       <= RegWrite_in;
            r_acc_m2r      <= MemtoReg_in;
            r_acc_rd       <= Rd_in;
            r_cnt          <= '0;
            r_valid_out    <= 1'b0;
            r_regwrite_out <= 1'b0;
          end else begin
            r_valid_out    <= 1'b1;
            r_regwrite_out <= RegWrite_in & ~w_bad & (Rd_in != 5'd0);
            r_memtoreg_out <= MemtoReg_in;
            r_rdata_out    <= '0;
            r_alu_out      <= AluOut_in;
            r_rd_out       <= Rd_in;
            r_err_misalign <= w_bad;
          end
        end
        ST_ACCESS: begin
          if (w_done || w_tmo) begin
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_valid_out    <= 1'b1;
            r_regwrite_out <= w_done & r_acc_rw & (r_acc_rd != 5'd0);
            r_memtoreg_out <= r_acc_m2r;
            r_rdata_out    <= (w_done && !r_mem_we) ? mem_rdata : 64'd0;
            r_alu_out      <= r_mem_addr;
            r_rd_out       <= r_acc_rd;
            r_err_timeout  <= w_tmo;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign valid_out    = r_valid_out;
  assign RegWrite_Out = r_regwrite_out;
  assign MemtoReg_Out = r_memtoreg_out;
  assign ReadData_Out = r_rdata_out;
  assign AluOut_Out   = r_alu_out;
  assign Rd_out       = r_rd_out;
  assign err_misalign = r_err_misalign;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit against a transaction-level model.
// Latency: each instruction is driven, then its result checked one edge after completion.
// Backpressure: the bench holds EX/MEM inputs for the whole access, as a stalled pipeline would.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, RegWrite_in, MemtoReg_in, MemWrite_in, MemRead_in;
  logic [63:0] AluOut_in, DataOut_in;
  logic [4:0]  Rd_in;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        valid_out, RegWrite_Out, MemtoReg_Out;
  logic [63:0] ReadData_Out, AluOut_Out;
  logic [4:0]  Rd_out;
  logic        err_misalign, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  // Expected values of the data outputs that hold across idle cycles.
  logic        e_m2r;
  logic [63:0] e_rdata, e_alu;
  logic [4:0]  e_rd;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .AluOut_in(AluOut_in), .DataOut_in(DataOut_in), .Rd_in(Rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
    .valid_out(valid_out), .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .ReadData_Out(ReadData_Out), .AluOut_Out(AluOut_Out), .Rd_out(Rd_out),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_result(input logic v, input logic rw, input logic em, input logic et);
    chk("valid_out", valid_out, v);
    chk("RegWrite_Out", RegWrite_Out, rw);
    chk("MemtoReg_Out", MemtoReg_Out, e_m2r);
    chk("ReadData_Out", ReadData_Out, e_rdata);
    chk("AluOut_Out", AluOut_Out, e_alu);
    chk("Rd_out", Rd_out, e_rd);
    chk("err_misalign", err_misalign, em);
    chk("err_timeout", err_timeout, et);
    chk("mem_req_after", mem_req, 1'b0);
  endtask

  // One instruction through the stage. lat = ACCESS cycle (1-based) in which memory answers.
  task automatic do_instr(input logic v, input logic rw, input logic m2r, input logic mw,
                          input logic mr, input logic [63:0] alu, input logic [63:0] dat,
                          input logic [4:0] rd, input int lat, input logic [63:0] rdat);
    logic is_op, bad, acc, tmo;
    int   nacc;
    logic [2:0] low;
    low   = alu[2:0];
    is_op = v & (mr ^ mw);
    bad   = v & ((mr & mw) | (is_op & (low != 3'd0)));
    acc   = is_op & ~bad;
    if (lat < 1) lat = 1;
    tmo   = acc && (lat > TIMEOUT);
    nacc  = (lat > TIMEOUT) ? TIMEOUT : lat;

    @(negedge clk);
    valid_in = v; RegWrite_in = rw; MemtoReg_in = m2r; MemWrite_in = mw; MemRead_in = mr;
    AluOut_in = alu; DataOut_in = dat; Rd_in = rd;
    mem_ready = acc ? 1'b0 : 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    #1;
    chk("stall_idle", stall, acc);
    chk("mem_req_idle", mem_req, 1'b0);
    @(posedge clk); #1;

    if (!acc) begin
      mem_ready = 1'b0;
      if (v) begin
        e_m2r = m2r; e_rdata = 64'd0; e_alu = alu; e_rd = rd;
        chk_result(1'b1, rw & ~bad & (rd != 5'd0), bad, 1'b0);
      end else begin
        chk_result(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end else begin
      for (int k = 1; k <= nacc; k++) begin
        chk("mem_req", mem_req, 1'b1);
        chk("mem_we", mem_we, mw);
        chk("mem_addr", mem_addr, alu);
        chk("mem_wdata", mem_wdata, dat);
        chk("valid_busy", valid_out, 1'b0);
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? rdat : {$urandom, $urandom};
        #1;
        chk("stall_acc", stall, k < nacc);
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      e_m2r = m2r; e_alu = alu; e_rd = rd;
      e_rdata = (tmo || mw) ? 64'd0 : rdat;
      chk_result(1'b1, ~tmo & rw & (rd != 5'd0), 1'b0, tmo);
    end
  endtask

  // Reset in the second ACCESS cycle of a load, with mem_ready also high.
  task automatic reset_mid();
    @(negedge clk);
    valid_in = 1; RegWrite_in = 1; MemtoReg_in = 1; MemWrite_in = 0; MemRead_in = 1;
    AluOut_in = 64'h40; DataOut_in = 64'h0; Rd_in = 5'd9; mem_ready = 0;
    @(posedge clk); #1;
    chk("rst_acc1_req", mem_req, 1'b1);
    @(posedge clk); #1;
    chk("rst_acc2_req", mem_req, 1'b1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 64'h1111;
    #1;
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; valid_in = 1'b0;
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_we", mem_we, 1'b0);
    e_m2r = 0; e_rdata = 0; e_alu = 0; e_rd = 0;
    chk_result(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 64'd0;
    valid_in = 1; RegWrite_in = 1; MemtoReg_in = 1; MemWrite_in = 0; MemRead_in = 1;
    AluOut_in = 64'h100; DataOut_in = 64'h0; Rd_in = 5'd3;
    e_m2r = 0; e_rdata = 0; e_alu = 0; e_rd = 0;
    @(negedge clk); #1;
    chk("stall_in_reset", stall, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_mem_we", mem_we, 1'b0);
    chk_result(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; valid_in = 1'b0;

    do_instr(1, 1, 0, 0, 0, 64'h1234, 64'h0, 5'd5, 1, 64'h0);          // ALU op
    do_instr(1, 1, 1, 0, 1, 64'h100, 64'h0, 5'd7, 3, 64'hDEADBEEF);     // load, 3 cycles
    do_instr(1, 0, 0, 1, 0, 64'h208, 64'hA5A5, 5'd3, 1, 64'hFFFF);      // store
    do_instr(0, 0, 0, 0, 0, 64'h999, 64'h0, 5'd1, 1, 64'h0);            // bubble holds data
    do_instr(1, 1, 1, 0, 1, 64'h103, 64'h0, 5'd4, 1, 64'h0);            // misaligned load
    do_instr(1, 1, 1, 0, 1, 64'h300, 64'h0, 5'd8, TIMEOUT + 5, 64'h0);  // timeout
    do_instr(1, 1, 1, 0, 1, 64'h308, 64'h0, 5'd8, TIMEOUT, 64'h77);     // ready on last cycle
    do_instr(1, 1, 0, 1, 1, 64'h400, 64'h1, 5'd6, 1, 64'h0);            // illegal op
    do_instr(1, 1, 0, 0, 0, 64'h55, 64'h0, 5'd0, 1, 64'h0);             // Rd=0
    do_instr(1, 1, 1, 0, 1, 64'h500, 64'h0, 5'd0, 2, 64'h42);           // load to Rd=0
    reset_mid();
    do_instr(1, 1, 0, 0, 0, 64'hABC, 64'h0, 5'd12, 1, 64'h0);           // after reset

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [63:0] a;
      logic [4:0]  r;
      kind = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      r = (kind == 9) ? 5'd0 : 5'($urandom_range(1, 31));
      case (kind)
        0:       do_instr(0, 1'($urandom), 1'($urandom), 0, 0, a, {$urandom, $urandom}, r, 1, 0);
        1, 2:    do_instr(1, 1'($urandom), 1'($urandom), 0, 0, a, {$urandom, $urandom}, r, 1, 0);
        3, 4, 5: do_instr(1, 1'($urandom), 1'($urandom), 0, 1, a, 64'd0, r,
                          $urandom_range(1, TIMEOUT + 2), {$urandom, $urandom});
        6, 7:    do_instr(1, 1'($urandom), 1'($urandom), 1, 0, a, {$urandom, $urandom}, r,
                          $urandom_range(1, TIMEOUT + 2), {$urandom, $urandom});
        8:       do_instr(1, 1'($urandom), 1'($urandom), 1, 1, a, {$urandom, $urandom}, r, 1, 0);
        default: do_instr(1, 1, 1'($urandom), 0, 1'($urandom), a, 64'd0, r,
                          $urandom_range(1, 4), {$urandom, $urandom});
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
